// File: rtl/wb_dest_pipe_pkg.sv
// Shared constants for the writeback destination stage: destination modes,
// entry field layout and default link parameters.
package wb_dest_pipe_pkg;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    localparam int unsigned REGS_DEF      = 5;
    localparam int unsigned NB_DATA_DEF   = 32;
    localparam int unsigned LINK_REG_DEF  = 31;
    localparam int unsigned PC_OFFSET_DEF = 8;

    // Entry record, MSB first: valid, wen, addr, data. Modules declare the
    // packed struct locally in this order so widths follow their parameters.
    localparam int unsigned ENTRY_FIELDS = 4;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Priority search of the in-flight entries for one register query;
// entry 0 is the youngest and wins over older matches.
module wb_fwd_lookup #(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned REGS    = 5,
    parameter int unsigned NB_DATA = 32
) (
    input  logic [REGS-1:0]                  i_q,
    input  logic [STAGES-1:0]                i_wen,
    input  logic [STAGES-1:0][REGS-1:0]      i_addr,
    input  logic [STAGES-1:0][NB_DATA-1:0]   i_data,
    output logic                             o_hit,
    output logic [NB_DATA-1:0]               o_data
);

    // Walk oldest to youngest so the youngest match overwrites the result.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (i_wen[k] && (i_addr[k] == i_q) && (i_q != '0)) begin
                o_hit  = 1'b1;
                o_data = i_data[k];
            end
        end
    end

endmodule

// File: rtl/wb_dest_pipe.sv
// Writeback destination/data pipe with stall, flush-as-bubble and an
// optional forwarding lookup enabled by WB_DEST_FWD_EN.
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int unsigned REGS      = REGS_DEF,
    parameter int unsigned NB_DATA   = NB_DATA_DEF,
    parameter int unsigned LINK_REG  = LINK_REG_DEF,
    parameter int unsigned PC_OFFSET = PC_OFFSET_DEF,
    parameter int unsigned STAGES    = 2
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_valid,
    input  logic               i_stall,
    input  logic               i_flush,
    input  logic [1:0]         i_dst_mode,
    input  logic [REGS-1:0]    i_rt,
    input  logic [REGS-1:0]    i_rd,
    input  logic               i_reg_write,
    input  logic               i_mem_to_reg,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [NB_DATA-1:0] i_pc,
    input  logic [REGS-1:0]    i_rs_q,
    input  logic [REGS-1:0]    i_rt_q,
    output logic               o_wb_en,
    output logic [REGS-1:0]    o_wb_addr,
    output logic [NB_DATA-1:0] o_wb_data,
    output logic               o_fwd_a_hit,
    output logic [NB_DATA-1:0] o_fwd_a_data,
    output logic               o_fwd_b_hit,
    output logic [NB_DATA-1:0] o_fwd_b_data
);

    typedef struct packed {
        logic               valid;
        logic               wen;
        logic [REGS-1:0]    addr;
        logic [NB_DATA-1:0] data;
    } entry_t;

    entry_t [STAGES-1:0] ent_q;
    entry_t              ent_d;

    always_comb begin
        ent_d       = '0;
        ent_d.valid = i_valid;
        case (i_dst_mode)
            DST_RT:   ent_d.addr = i_rt;
            DST_RD:   ent_d.addr = i_rd;
            DST_LINK: ent_d.addr = REGS'(LINK_REG);
            default:  ent_d.addr = '0;
        endcase
        if (i_dst_mode == DST_LINK)
            ent_d.data = i_pc + NB_DATA'(PC_OFFSET);
        else
            ent_d.data = i_mem_to_reg ? i_mem_data : i_alu_result;
        // $0 is hardwired, so a write to it is never requested.
        ent_d.wen = i_valid & i_reg_write & (i_dst_mode != DST_NONE) & (ent_d.addr != '0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ent_q <= '0;
        end else if (!i_stall) begin
            ent_q[0] <= i_flush ? entry_t'('0) : ent_d;
            for (int k = 1; k < STAGES; k++)
                ent_q[k] <= ent_q[k-1];
        end
    end

    assign o_wb_en   = ent_q[STAGES-1].wen & ent_q[STAGES-1].valid;
    assign o_wb_addr = ent_q[STAGES-1].addr;
    assign o_wb_data = ent_q[STAGES-1].data;

`ifdef WB_DEST_FWD_EN
    logic [STAGES-1:0]              fwd_wen;
    logic [STAGES-1:0][REGS-1:0]    fwd_addr;
    logic [STAGES-1:0][NB_DATA-1:0] fwd_data;

    for (genvar k = 0; k < STAGES; k++) begin : g_fwd_vec
        assign fwd_wen[k]  = ent_q[k].wen & ent_q[k].valid;
        assign fwd_addr[k] = ent_q[k].addr;
        assign fwd_data[k] = ent_q[k].data;
    end

    wb_fwd_lookup #(.STAGES(STAGES), .REGS(REGS), .NB_DATA(NB_DATA)) u_fwd_a (
        .i_q    (i_rs_q),
        .i_wen  (fwd_wen),
        .i_addr (fwd_addr),
        .i_data (fwd_data),
        .o_hit  (o_fwd_a_hit),
        .o_data (o_fwd_a_data)
    );

    wb_fwd_lookup #(.STAGES(STAGES), .REGS(REGS), .NB_DATA(NB_DATA)) u_fwd_b (
        .i_q    (i_rt_q),
        .i_wen  (fwd_wen),
        .i_addr (fwd_addr),
        .i_data (fwd_data),
        .o_hit  (o_fwd_b_hit),
        .o_data (o_fwd_b_data)
    );
`else
    logic unused_fwd_q;
    assign unused_fwd_q = ^{i_rs_q, i_rt_q};

    assign o_fwd_a_hit  = 1'b0;
    assign o_fwd_a_data = '0;
    assign o_fwd_b_hit  = 1'b0;
    assign o_fwd_b_data = '0;
`endif

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Directed bench for wb_dest_pipe (STAGES=2); forwarding expectations follow
// whether WB_DEST_FWD_EN is defined for the build.
module tb_wb_dest_pipe;

`ifdef WB_DEST_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        i_clk, i_reset_n, i_valid, i_stall, i_flush;
    logic [1:0]  i_dst_mode;
    logic [4:0]  i_rt, i_rd, i_rs_q, i_rt_q;
    logic        i_reg_write, i_mem_to_reg;
    logic [31:0] i_alu_result, i_mem_data, i_pc;
    logic        o_wb_en, o_fwd_a_hit, o_fwd_b_hit;
    logic [4:0]  o_wb_addr;
    logic [31:0] o_wb_data, o_fwd_a_data, o_fwd_b_data;

    int n_chk  = 0;
    int n_fail = 0;

    wb_dest_pipe #(.STAGES(2)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid),
        .i_stall(i_stall), .i_flush(i_flush), .i_dst_mode(i_dst_mode),
        .i_rt(i_rt), .i_rd(i_rd), .i_reg_write(i_reg_write),
        .i_mem_to_reg(i_mem_to_reg), .i_alu_result(i_alu_result),
        .i_mem_data(i_mem_data), .i_pc(i_pc), .i_rs_q(i_rs_q), .i_rt_q(i_rt_q),
        .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
        .o_fwd_a_hit(o_fwd_a_hit), .o_fwd_a_data(o_fwd_a_data),
        .o_fwd_b_hit(o_fwd_b_hit), .o_fwd_b_data(o_fwd_b_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] mode, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
        i_valid = v; i_dst_mode = mode; i_rt = rt; i_rd = rd; i_reg_write = rw;
        i_mem_to_reg = m2r; i_alu_result = alu; i_mem_data = mem; i_pc = pc;
    endtask

    task automatic idle();
        drive(1'b0, 2'b11, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic en, input logic [4:0] addr, input logic [31:0] data);
        chk({tag, "_en"},   {31'd0, o_wb_en}, {31'd0, en});
        chk({tag, "_addr"}, {27'd0, o_wb_addr}, {27'd0, addr});
        chk({tag, "_data"}, o_wb_data, data);
    endtask

    initial begin
        i_reset_n = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
        i_rs_q = 5'd0; i_rt_q = 5'd0;
        idle();
        #12;
        chk_wb("rst", 1'b0, 5'd0, 32'h0);
        chk("rst_fwd_a", {31'd0, o_fwd_a_hit}, 32'd0);
        chk("rst_fwd_b", {31'd0, o_fwd_b_hit}, 32'd0);
        i_reset_n = 1'b1;

        // rd write: visible at o_wb two edges later
        drive(1'b1, 2'b01, 5'd3, 5'd5, 1'b1, 1'b0, 32'h1234, 32'h9999, 32'h0);
        i_rs_q = 5'd5;
        step();
        chk("s1_fwd_hit",  {31'd0, o_fwd_a_hit}, {31'd0, FWD});
        chk("s1_fwd_data", o_fwd_a_data, FWD ? 32'h1234 : 32'h0);
        chk("s1_early_en", {31'd0, o_wb_en}, 32'd0);
        idle();
        step();
        chk_wb("s1", 1'b1, 5'd5, 32'h1234);

        // link mode with PC wrap
        drive(1'b1, 2'b10, 5'd1, 5'd2, 1'b1, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFFC);
        step(); idle(); step();
        chk_wb("s2", 1'b1, 5'd31, 32'h0000_0004);

        // write to $0 suppressed, $0 never forwards
        drive(1'b1, 2'b00, 5'd0, 5'd6, 1'b1, 1'b0, 32'h55, 32'h0, 32'h0);
        i_rs_q = 5'd0;
        step();
        chk("s3_fwd0", {31'd0, o_fwd_a_hit}, 32'd0);
        idle(); step();
        chk_wb("s3", 1'b0, 5'd0, 32'h55);

        // memory data select, reg_write=0 disables
        drive(1'b1, 2'b01, 5'd0, 5'd9, 1'b0, 1'b1, 32'h1, 32'hDEAD, 32'h0);
        step(); idle(); step();
        chk_wb("s3b", 1'b0, 5'd9, 32'hDEAD);
        // mode none
        drive(1'b1, 2'b11, 5'd4, 5'd9, 1'b1, 1'b1, 32'h1, 32'hBEEF, 32'h0);
        step(); idle(); step();
        chk_wb("s3c", 1'b0, 5'd0, 32'hBEEF);

        // youngest match wins, stall holds, flush inserts bubble
        i_rs_q = 5'd7; i_rt_q = 5'd3;
        drive(1'b1, 2'b01, 5'd0, 5'd7, 1'b1, 1'b0, 32'hA, 32'h0, 32'h0);
        step();
        drive(1'b1, 2'b01, 5'd0, 5'd7, 1'b1, 1'b0, 32'hB, 32'h0, 32'h0);
        step();
        chk_wb("s4", 1'b1, 5'd7, 32'hA);
        chk("s4_fwd_hit",  {31'd0, o_fwd_a_hit}, {31'd0, FWD});
        chk("s4_fwd_data", o_fwd_a_data, FWD ? 32'hB : 32'h0);
        chk("s4_fwdb_miss", {31'd0, o_fwd_b_hit}, 32'd0);
        i_stall = 1'b1;
        drive(1'b1, 2'b01, 5'd0, 5'd12, 1'b1, 1'b0, 32'hC, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            i_flush = (c == 1);
            step();
            chk_wb("s4_stall", 1'b1, 5'd7, 32'hA);
            chk("s4_stall_fwd", o_fwd_a_data, FWD ? 32'hB : 32'h0);
        end
        i_stall = 1'b0; i_flush = 1'b1;
        step();
        chk_wb("s4_fl1", 1'b1, 5'd7, 32'hB);
        chk("s4_fl1_fwd", o_fwd_a_data, FWD ? 32'hB : 32'h0);
        i_flush = 1'b0; idle();
        step();
        chk_wb("s4_fl2", 1'b0, 5'd0, 32'h0);
        chk("s4_fl2_fwd", {31'd0, o_fwd_a_hit}, 32'd0);

        // asynchronous reset mid-stream
        i_rs_q = 5'd11; i_rt_q = 5'd10;
        drive(1'b1, 2'b01, 5'd0, 5'd10, 1'b1, 1'b0, 32'h77, 32'h0, 32'h0);
        step();
        drive(1'b1, 2'b01, 5'd0, 5'd11, 1'b1, 1'b0, 32'h88, 32'h0, 32'h0);
        step();
        chk_wb("s5_pre", 1'b1, 5'd10, 32'h77);
        chk("s5_pre_fwd", {31'd0, o_fwd_a_hit}, {31'd0, FWD});
        #2 i_reset_n = 1'b0;
        #1;
        chk_wb("s5_rst", 1'b0, 5'd0, 32'h0);
        chk("s5_rst_fwda", {31'd0, o_fwd_a_hit}, 32'd0);
        chk("s5_rst_fwdb", {31'd0, o_fwd_b_hit}, 32'd0);
        idle();
        #3 i_reset_n = 1'b1;
        step();
        chk_wb("s5_post", 1'b0, 5'd0, 32'h0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
